// File: rtl/riscv_dmem_arbiter.sv
// Data-SRAM arbiter: EX load/store port vs. sensor DMA loader, core priority with starvation override.
// Optional DMEM_ARB_PERF_EN builds saturating stall / DMA-beat performance counters.
module riscv_dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_en,
    input  logic              core_we,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    input  logic              dma_valid,
    output logic              dma_ready,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              err_oor,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_dma_cnt
);
    typedef enum logic [1:0] {IDLE, CRD, DRD} state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_q;
    logic       oor_q, oor_d;
    logic       core_oor, dma_oor, dma_win;

    // Byte-offset bits never reach the word-addressed SRAM.
    logic unused_ok;
    assign unused_ok = ^{core_addr[1:0], dma_addr[1:0]};

    assign core_oor = |core_addr[31:ADDR_W+2];
    assign dma_oor  = |dma_addr[31:ADDR_W+2];
    assign dma_win  = dma_valid && (!core_en || (wait_q >= WAIT_LIMIT));

    always_comb begin
        state_d    = IDLE;
        oor_d      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        dma_ready  = 1'b0;
        core_stall = 1'b0;
        err_oor    = 1'b0;
        core_rdata = '0;
        dma_rvalid = 1'b0;
        dma_rdata  = '0;
        case (state_q)
            IDLE: begin
                if (dma_win) begin
                    dma_ready  = 1'b1;
                    mem_en     = !dma_oor;
                    mem_we     = dma_we && !dma_oor;
                    mem_addr   = dma_addr[ADDR_W+1:2];
                    mem_wdata  = dma_wdata;
                    err_oor    = dma_oor;
                    core_stall = core_en;
                    if (!dma_we) begin
                        state_d = DRD;
                        oor_d   = dma_oor;
                    end
                end else if (core_en) begin
                    mem_en     = !core_oor;
                    mem_we     = core_we && !core_oor;
                    mem_addr   = core_addr[ADDR_W+1:2];
                    mem_wdata  = core_wdata;
                    err_oor    = core_oor;
                    core_stall = !core_we;
                    if (!core_we) begin
                        state_d = CRD;
                        oor_d   = core_oor;
                    end
                end
            end
            CRD: begin
                // The core's request is still on the bus here; it was already served.
                core_rdata = oor_q ? 32'd0 : mem_rdata;
            end
            DRD: begin
                dma_rvalid = 1'b1;
                dma_rdata  = oor_q ? 32'd0 : mem_rdata;
                core_stall = core_en;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            state_d    = IDLE;
            oor_d      = 1'b0;
            mem_en     = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
            dma_ready  = 1'b0;
            core_stall = 1'b0;
            err_oor    = 1'b0;
            core_rdata = '0;
            dma_rvalid = 1'b0;
            dma_rdata  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            oor_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            oor_q   <= oor_d;
            if (dma_ready)
                wait_q <= '0;
            else if (dma_valid && (wait_q != 4'hF))
                wait_q <= wait_q + 4'd1;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q, dma_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            dma_cnt_q   <= '0;
        end else begin
            if (core_stall && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (dma_valid && dma_ready && (dma_cnt_q != 32'hFFFF_FFFF))
                dma_cnt_q <= dma_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_dma_cnt   = dma_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_dma_cnt   = '0;
`endif
endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: directed scenarios then randomized traffic against a transaction-level model.
module tb_riscv_dmem_arbiter;
    localparam int ADDR_W   = 10;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              core_en, core_we, dma_valid, dma_we;
    logic [31:0]       core_addr, core_wdata, dma_addr, dma_wdata;
    logic [31:0]       core_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic              core_stall, dma_ready, dma_rvalid, mem_en, mem_we, err_oor;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       perf_stall_cnt, perf_dma_cnt;

    always #5 clk = ~clk;

    riscv_dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_en(core_en), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err_oor(err_oor),
        .perf_stall_cnt(perf_stall_cnt), .perf_dma_cnt(perf_dma_cnt)
    );

    // SRAM macro stand-in
    logic [31:0] sram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: what the memory should hold, and what data is owed next cycle.
    logic [31:0] shadow [DEPTH];
    int          m_owed;      // 0 none, 1 core load data, 2 DMA load data
    logic [31:0] m_owed_data;
    int          m_blocked;   // consecutive cycles the DMA has waited
    logic [31:0] m_stalls, m_beats;

    // Observations from the latest step
    logic        o_stall, o_ready, o_rvalid, o_err, o_en, o_we;
    logic [31:0] o_addr, o_crdata, o_drdata;
    logic [31:0] o_pstall, o_pdma;

    task automatic model_reset();
        m_owed = 0; m_owed_data = 0; m_blocked = 0; m_stalls = 0; m_beats = 0;
    endtask

    task automatic step(input logic ce, input logic cwe, input logic [31:0] ca, input logic [31:0] cwd,
                        input logic dv, input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        logic        e_stall, e_ready, e_rvalid, e_err, e_en, e_we, dgo, cgo, swe, oor;
        logic [31:0] e_crdata, e_drdata, e_addr, e_wdata, sa, sd;
        int          nxt_owed;
        core_en = ce; core_we = cwe; core_addr = ca; core_wdata = cwd;
        dma_valid = dv; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
        @(negedge clk);
        e_stall = 0; e_ready = 0; e_rvalid = 0; e_err = 0; e_en = 0; e_we = 0;
        e_crdata = 0; e_drdata = 0; e_addr = 0; e_wdata = 0; nxt_owed = 0;
        if (m_owed == 1) begin
            e_crdata = m_owed_data;
        end else if (m_owed == 2) begin
            e_rvalid = 1; e_drdata = m_owed_data; e_stall = ce;
        end else begin
            dgo = dv && (!ce || m_blocked >= MAX_WAIT);
            cgo = !dgo && ce;
            if (dgo || cgo) begin
                sa  = dgo ? da  : ca;
                sd  = dgo ? dwd : cwd;
                swe = dgo ? dwe : cwe;
                oor = sa >= (32'd4 << ADDR_W);
                e_err   = oor;
                e_en    = !oor;
                e_we    = !oor && swe;
                e_addr  = (sa % (32'd4 << ADDR_W)) / 4;
                e_wdata = sd;
                if (!swe) begin
                    nxt_owed    = dgo ? 2 : 1;
                    m_owed_data = oor ? 32'd0 : shadow[e_addr];
                end else if (!oor) begin
                    shadow[e_addr] = sd;
                end
            end
            e_ready = dgo;
            e_stall = dgo ? ce : (cgo && !cwe);
        end
        o_stall = core_stall; o_ready = dma_ready; o_rvalid = dma_rvalid; o_err = err_oor;
        o_en = mem_en; o_we = mem_we; o_addr = 32'(mem_addr); o_crdata = core_rdata;
        o_drdata = dma_rdata; o_pstall = perf_stall_cnt; o_pdma = perf_dma_cnt;
        check_val("core_stall", 32'(o_stall), 32'(e_stall));
        check_val("dma_ready", 32'(o_ready), 32'(e_ready));
        check_val("dma_rvalid", 32'(o_rvalid), 32'(e_rvalid));
        check_val("err_oor", 32'(o_err), 32'(e_err));
        check_val("mem_en", 32'(o_en), 32'(e_en));
        check_val("core_rdata", o_crdata, e_crdata);
        check_val("dma_rdata", o_drdata, e_drdata);
        if (e_en) begin
            check_val("mem_we", 32'(o_we), 32'(e_we));
            check_val("mem_addr", o_addr, e_addr);
            if (e_we) check_val("mem_wdata", mem_wdata, e_wdata);
        end
`ifdef DMEM_ARB_PERF_EN
        check_val("perf_stall_cnt", o_pstall, m_stalls);
        check_val("perf_dma_cnt", o_pdma, m_beats);
`else
        check_val("perf_stall_cnt", o_pstall, 32'd0);
        check_val("perf_dma_cnt", o_pdma, 32'd0);
`endif
        if (e_stall && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
        if (e_ready && m_beats != 32'hFFFF_FFFF) m_beats = m_beats + 1;
        if (e_ready) m_blocked = 0;
        else if (dv && m_blocked < 15) m_blocked = m_blocked + 1;
        m_owed = nxt_owed;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        core_en = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dma_valid = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic        r_ce, r_cwe, r_dv, r_dwe;
    logic [31:0] r_ca, r_cwd, r_da, r_dwd;

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 32'h0000_1000 | $urandom();
        return {22'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram[i] = 32'd0;
            shadow[i] = 32'd0;
        end
        mem_rdata = 32'd0;
        do_reset();
        check_val("reset core_stall", 32'(core_stall), 32'd0);
        check_val("reset perf_stall", perf_stall_cnt, 32'd0);

        // Core store then load
        step(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
        check_val("st stall", 32'(o_stall), 32'd0);
        check_val("st mem_we", 32'(o_we), 32'd1);
        check_val("st mem_addr", o_addr, 32'd4);
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);
        check_val("ld stall", 32'(o_stall), 32'd1);
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);
        check_val("ld rdata", o_crdata, 32'hDEAD_BEEF);
        check_val("ld crd stall", 32'(o_stall), 32'd0);

        // DMA write then read with core idle
        step(0, 0, 0, 0, 1, 1, 32'h20, 32'h55);
        check_val("dma wr ready", 32'(o_ready), 32'd1);
        check_val("dma wr addr", o_addr, 32'd8);
        step(0, 0, 0, 0, 1, 0, 32'h20, 0);
        check_val("dma rd ready", 32'(o_ready), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("dma rvalid", 32'(o_rvalid), 32'd1);
        check_val("dma rdata", o_drdata, 32'h55);

        // Starvation override: continuous core loads, DMA pending
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 32'h40, 0, 1, 1, 32'h30, 32'h77);
            check_val("starve ready", 32'(o_ready), (i == 4) ? 32'd1 : 32'd0);
            check_val("starve stall", 32'(o_stall), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        step(1, 0, 32'h40, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_PERF_EN
        check_val("perf stalls", o_pstall, 32'd3);
        check_val("perf beats", o_pdma, 32'd1);
`else
        check_val("perf stalls off", o_pstall, 32'd0);
        check_val("perf beats off", o_pdma, 32'd0);
`endif
        step(1, 0, 32'h40, 0, 0, 0, 0, 0);

        // Out-of-range core load with stale SRAM data on the bus
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);
        step(1, 0, 32'h0001_0000, 0, 0, 0, 0, 0);
        check_val("oor err", 32'(o_err), 32'd1);
        check_val("oor mem_en", 32'(o_en), 32'd0);
        step(1, 0, 32'h0001_0000, 0, 0, 0, 0, 0);
        check_val("oor rdata", o_crdata, 32'd0);

        // Reset in the core read-data cycle
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_val("rst core_rdata", core_rdata, 32'd0);
        check_val("rst core_stall", 32'(core_stall), 32'd0);
        check_val("rst mem_en", 32'(mem_en), 32'd0);
        check_val("rst mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst dma_ready", 32'(dma_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);
        check_val("post rst stall", 32'(o_stall), 32'd1);
        check_val("post rst rdata", o_crdata, 32'd0);
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);

        // Randomized traffic; requesters hold while stalled / not accepted
        r_ce = 0; r_cwe = 0; r_ca = 0; r_cwd = 0; r_dv = 0; r_dwe = 0; r_da = 0; r_dwd = 0;
        o_stall = 0; o_ready = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(r_ce && o_stall)) begin
                r_ce = ($urandom_range(0, 2) != 0); r_cwe = $urandom_range(0, 1) == 1;
                r_ca = rand_addr(); r_cwd = $urandom();
            end
            if (!(r_dv && !o_ready)) begin
                r_dv = ($urandom_range(0, 1) == 1); r_dwe = $urandom_range(0, 1) == 1;
                r_da = rand_addr(); r_dwd = $urandom();
            end
            step(r_ce, r_cwe, r_ca, r_cwd, r_dv, r_dwe, r_da, r_dwd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
